// File: rtl/alu_sched_if.sv
`default_nettype none
// =====================================================================
// Module   : alu_sched_if
// Purpose  : Two-port request/response bundle for the shared-ALU scheduler.
// Revision : 1.0
// =====================================================================
interface alu_sched_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [5:0]   req_cmd;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [63:0]  resp_data;
  logic         resp_cout;
  logic         resp_zero;
  logic         resp_err;

  modport master (
    output req_valid, req_cmd, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_cout, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_cout, resp_zero, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// =====================================================================
// Module   : alu_sched
// Purpose  : Arbitrates two ports onto one 32-bit ALU; 64-bit ops take two passes.
// Revision : 1.0
// =====================================================================
module alu_sched #(
  parameter int RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  alu_sched_if.slave  bus,
  output logic        busy,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [1:0]  alu_op,
  output logic        alu_binvert,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic        alu_cout,
  input  logic        alu_zero
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] c_OP_AND = 2'b00;
  localparam logic [1:0] c_OP_OR  = 2'b01;
  localparam logic [1:0] c_OP_ADD = 2'b10;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_port;
  logic [2:0]  r_cmd;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        r_lo_cout;
  logic        r_lo_zero;
  logic        r_hi_cout;
  logic        r_hi_zero;
  logic        r_last_grant;

  logic [1:0]  w_grant;
  logic        w_sel_port;
  logic [2:0]  w_sel_cmd;
  logic        w_transfer;
  logic        w_resp_done;
  logic        w_illegal;

  assign w_illegal  = (r_cmd[2:1] == 2'b11);
  assign w_sel_port = w_grant[1];
  assign w_sel_cmd  = w_sel_port ? bus.req_cmd[5:3] : bus.req_cmd[2:0];
  assign w_transfer = |w_grant;
  assign bus.req_ready = w_grant;
  assign busy = (r_state != IDLE);

  // Grant is only offered from IDLE; on a tie round-robin favours the port not served last.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == IDLE && !rst) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (RR_ENABLE != 0 && !r_last_grant) ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_resp_done    = 1'b0;
    alu_in1        = 32'h0;
    alu_in2        = 32'h0;
    alu_op         = c_OP_AND;
    alu_binvert    = 1'b0;
    alu_cin        = 1'b0;
    bus.resp_valid = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_transfer) w_next_state = (w_sel_cmd[2:1] == 2'b11) ? RESP : EXEC_LO;
      end
      EXEC_LO: begin
        alu_in1 = r_a[31:0];
        alu_in2 = r_b[31:0];
        case (r_cmd)
          3'b000:         alu_op = c_OP_AND;
          3'b001:         alu_op = c_OP_OR;
          3'b011, 3'b101: begin alu_op = c_OP_ADD; alu_binvert = 1'b1; end
          default:        alu_op = c_OP_ADD;
        endcase
        w_next_state = r_cmd[2] ? EXEC_HI : RESP;
      end
      EXEC_HI: begin
        // The ALU forces cin=1 under binvert, so the borrow chain uses a pre-inverted operand.
        alu_in1      = r_a[63:32];
        alu_in2      = r_cmd[0] ? ~r_b[63:32] : r_b[63:32];
        alu_op       = c_OP_ADD;
        alu_cin      = r_lo_cout;
        w_next_state = RESP;
      end
      RESP: begin
        bus.resp_valid = r_port ? 2'b10 : 2'b01;
        if (bus.resp_ready[r_port]) begin
          w_resp_done  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.resp_data = 64'h0;
    bus.resp_cout = 1'b0;
    bus.resp_zero = 1'b0;
    bus.resp_err  = 1'b0;
    if (r_state == RESP) begin
      if (w_illegal) begin
        bus.resp_err = 1'b1;
      end else if (r_cmd[2]) begin
        bus.resp_data = {r_hi, r_lo};
        bus.resp_cout = r_hi_cout;
        bus.resp_zero = r_lo_zero & r_hi_zero;
      end else begin
        bus.resp_data = {32'h0, r_lo};
        bus.resp_cout = r_cmd[1] & r_lo_cout;
        bus.resp_zero = r_lo_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_port       <= 1'b0;
      r_cmd        <= 3'b000;
      r_a          <= 64'h0;
      r_b          <= 64'h0;
      r_lo         <= 32'h0;
      r_hi         <= 32'h0;
      r_lo_cout    <= 1'b0;
      r_lo_zero    <= 1'b0;
      r_hi_cout    <= 1'b0;
      r_hi_zero    <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            r_port <= w_sel_port;
            r_cmd  <= w_sel_cmd;
            r_a    <= w_sel_port ? bus.req_a[127:64] : bus.req_a[63:0];
            r_b    <= w_sel_port ? bus.req_b[127:64] : bus.req_b[63:0];
          end
        end
        EXEC_LO: begin
          r_lo      <= alu_out;
          r_lo_cout <= alu_cout;
          r_lo_zero <= alu_zero;
        end
        EXEC_HI: begin
          r_hi      <= alu_out;
          r_hi_cout <= alu_cout;
          r_hi_zero <= alu_zero;
        end
        RESP: begin
          if (w_resp_done) r_last_grant <= r_port;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// =====================================================================
// Module   : tb_alu_sched
// Purpose  : Directed self-checking bench for alu_sched with a behavioural ALU.
// Revision : 1.0
// =====================================================================
module tb_alu_sched;
  typedef struct {
    logic [63:0] data;
    logic        cout;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   gq[$];

  always #5 clk = ~clk;

  alu_sched_if if0();
  alu_sched_if if1();

  logic        busy0, busy1;
  logic [31:0] in1_0, in2_0, out0, in1_1, in2_1, out1;
  logic [1:0]  op0, op1;
  logic        bi0, ci0, co0, z0, bi1, ci1, co1, z1;

  alu_sched #(.RR_ENABLE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(if0), .busy(busy0),
    .alu_in1(in1_0), .alu_in2(in2_0), .alu_op(op0), .alu_binvert(bi0), .alu_cin(ci0),
    .alu_out(out0), .alu_cout(co0), .alu_zero(z0)
  );

  alu_sched #(.RR_ENABLE(0)) u_dut_fp (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1),
    .alu_in1(in1_1), .alu_in2(in2_1), .alu_op(op1), .alu_binvert(bi1), .alu_cin(ci1),
    .alu_out(out1), .alu_cout(co1), .alu_zero(z1)
  );

  // Shared 32-bit ALU: cin is forced to 1 whenever binvert is set.
  function automatic logic [33:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op, input logic bi, input logic ci);
    logic [31:0] yy;
    logic [31:0] r;
    logic [32:0] s;
    logic        c;
    yy = bi ? ~y : y;
    c  = 1'b0;
    if (op == 2'b00)      r = x & yy;
    else if (op == 2'b01) r = x | yy;
    else begin
      s = {1'b0, x} + {1'b0, yy} + {32'h0, (bi ? 1'b1 : ci)};
      r = s[31:0];
      c = s[32];
    end
    return {(r == 32'h0), c, r};
  endfunction

  always_comb {z0, co0, out0} = alu_f(in1_0, in2_0, op0, bi0, ci0);
  always_comb {z1, co1, out1} = alu_f(in1_1, in2_1, op1, bi1, ci1);

  function automatic exp_t ref_model(input logic [2:0] cmd, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [32:0] s33;
    logic [64:0] s65;
    e.data = 64'h0; e.cout = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    case (cmd)
      3'd0: e.data = {32'h0, a[31:0] & b[31:0]};
      3'd1: e.data = {32'h0, a[31:0] | b[31:0]};
      3'd2: begin
        s33 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        e.data = {32'h0, s33[31:0]};
        e.cout = s33[32];
      end
      3'd3: begin
        e.data = {32'h0, a[31:0] - b[31:0]};
        e.cout = (a[31:0] >= b[31:0]);
      end
      3'd4: begin
        s65 = {1'b0, a} + {1'b0, b};
        e.data = s65[63:0];
        e.cout = s65[64];
      end
      3'd5: begin
        e.data = a - b;
        e.cout = (a >= b);
      end
      default: e.err = 1'b1;
    endcase
    if (!e.err) e.zero = (e.data == 64'h0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on the round-robin instance; hold = cycles resp_ready stays low in RESP.
  task automatic txn(input int port, input logic [2:0] cmd, input logic [63:0] a,
                     input logic [63:0] b, input int lat, input int hold);
    exp_t       e;
    int         cnt;
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    if0.req_valid = 2'b00;
    if0.req_cmd[3*port +: 3] = cmd;
    if0.req_a[64*port +: 64] = a;
    if0.req_b[64*port +: 64] = b;
    if0.req_valid[port] = 1'b1;
    #1;
    check("grant", if0.req_ready, oh);
    sb.push_back(ref_model(cmd, a, b));
    @(posedge clk);
    #1;
    if0.req_valid = 2'b00;
    if0.req_cmd   = ~if0.req_cmd;
    if0.req_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
    if0.req_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
    cnt = 1;
    while (if0.resp_valid == 2'b00 && cnt < 8) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", cnt, lat);
    check("alu_idle_in_resp", {in1_0, in2_0, op0, bi0, ci0}, 68'h0);
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check("resp_valid", if0.resp_valid, oh);
      check("resp_data", if0.resp_data, e.data);
      check("resp_flags", {if0.resp_cout, if0.resp_zero, if0.resp_err}, {e.cout, e.zero, e.err});
      if (i < hold) begin
        @(posedge clk);
        #1;
      end
    end
    if0.resp_ready[port] = 1'b1;
    @(posedge clk);
    #1;
    if0.resp_ready = 2'b00;
    check("resp_drop", if0.resp_valid, 2'b00);
    check("busy_after", busy0, 1'b0);
  endtask

  initial begin
    int         got;
    int         cyc;
    logic [1:0] seen;
    rst = 1'b1;
    if0.req_valid = 2'b11; if0.req_cmd = 6'h0; if0.req_a = '0; if0.req_b = '0; if0.resp_ready = 2'b00;
    if1.req_valid = 2'b00; if1.req_cmd = 6'h0; if1.req_a = '0; if1.req_b = '0; if1.resp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", if0.req_ready, 2'b00);
    check("rst_resp_valid", if0.resp_valid, 2'b00);
    check("rst_resp", {if0.resp_data, if0.resp_cout, if0.resp_zero, if0.resp_err}, 67'h0);
    check("rst_busy", busy0, 1'b0);
    check("rst_alu", {in1_0, in2_0, op0, bi0, ci0}, 68'h0);
    if0.req_valid = 2'b00;
    rst = 1'b0;

    txn(0, 3'd2, 64'h0000_0000_7FFF_FFFF, 64'h1, 2, 0);
    txn(1, 3'd4, 64'h0000_0000_FFFF_FFFF, 64'h1, 3, 0);
    txn(0, 3'd5, 64'h0000_0001_0000_0000, 64'h1, 3, 0);
    txn(0, 3'd3, 64'h5, 64'h5, 2, 0);
    txn(1, 3'd7, 64'h1234_5678_9ABC_DEF0, 64'h1, 1, 5);
    txn(1, 3'd6, 64'h1, 64'h1, 1, 0);
    txn(1, 3'd0, 64'hFFFF_0000_F0F0_F0F0, 64'h0000_FFFF_FF00_FF00, 2, 0);
    txn(0, 3'd1, 64'hAAAA_AAAA_0000_0000, 64'h5555_5555_0000_0000, 2, 0);
    txn(1, 3'd3, 64'hFFFF_FFFF_0000_0003, 64'hFFFF_FFFF_0000_0005, 2, 0);
    txn(0, 3'd5, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 3, 2);

    // Reset while the high half of an ADD64 is on the ALU.
    @(negedge clk);
    if0.req_cmd[2:0] = 3'd4;
    if0.req_a[63:0]  = 64'h0000_0000_FFFF_FFFF;
    if0.req_b[63:0]  = 64'h1;
    if0.req_valid    = 2'b01;
    @(posedge clk);
    #1;
    if0.req_valid = 2'b00;
    @(posedge clk);
    #1;
    check("exec_hi_alu", {op0, bi0, ci0, in1_0, in2_0}, {2'b10, 1'b0, 1'b1, 32'h0, 32'h0});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy0, 1'b0);
    check("abort_resp_valid", if0.resp_valid, 2'b00);
    seen = 2'b00;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | if0.resp_valid;
    end
    check("abort_no_resp", seen, 2'b00);

    // Round-robin: both ports hold requests, responses accepted immediately.
    gq = '{0, 1, 0, 1};
    @(negedge clk);
    if0.req_cmd = 6'b000_000;
    if0.resp_ready = 2'b11;
    if0.req_valid = 2'b11;
    #1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      if (if0.req_ready != 2'b00) begin
        check("rr_grant", if0.req_ready, (gq.pop_front() == 1) ? 2'b10 : 2'b01);
        got++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    check("rr_count", got, 4);
    if0.req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    if0.resp_ready = 2'b00;

    // Fixed priority: port 0 keeps winning.
    gq = '{0, 0, 0};
    @(negedge clk);
    if1.resp_ready = 2'b11;
    if1.req_valid = 2'b11;
    #1;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 60) begin
      if (if1.req_ready != 2'b00) begin
        check("fp_grant", if1.req_ready, (gq.pop_front() == 1) ? 2'b10 : 2'b01);
        got++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    check("fp_count", got, 3);
    if1.req_valid = 2'b00;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter RR_ENABLE, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority (port 0 wins).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  2  per-port request valid (bit i = port i).
REQ-005 req_ready  output  2  per-port request accept; one-hot or zero.
REQ-006 req_cmd  input  6  per-port command, [3i+2:3i]: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 ADD64, 101 SUB64, 110/111 illegal.
REQ-007 req_a, req_b  input  128 each  per-port 64-bit operands, [64i+63:64i].
REQ-008 resp_valid  output  2  per-port response valid.
REQ-009 resp_ready  input  2  per-port response accept.
REQ-010 resp_data  output  64  result of granted port; resp_cout, resp_zero, resp_err  output  1 each.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 alu_in1, alu_in2  output  32 each; alu_op  output  2 (00 AND, 01 OR, 1x ADD); alu_binvert, alu_cin  output  1 each -- drive the shared 32-bit ALU.
REQ-013 alu_out  input  32; alu_cout, alu_zero  input  1 each -- combinational ALU results, sampled same cycle as driven.

Function
REQ-014 FSM states SHALL be IDLE, EXEC_LO, EXEC_HI, RESP.
REQ-015 In IDLE, req_ready SHALL be combinational one-hot grant of valid ports; a transfer occurs when req_valid[i] & req_ready[i]; req_ready SHALL be 0 in all other states.
REQ-016 Arbitration: RR_ENABLE=1 -> when both valid, grant the port not granted last (last_grant resets to 1, so port 0 wins first); RR_ENABLE=0 -> port 0 always wins ties.
REQ-017 On transfer, latch port index, cmd, a, b; next state EXEC_LO, or RESP directly if cmd illegal.
REQ-018 EXEC_LO: drive a[31:0], b[31:0]; AND -> op 00; OR -> op 01; ADD/ADD64 -> op 10, binvert 0, cin 0; SUB/SUB64 -> op 10, binvert 1; capture alu_out, alu_cout, alu_zero.
REQ-019 After EXEC_LO, 32-bit commands go to RESP; ADD64/SUB64 go to EXEC_HI.
REQ-020 EXEC_HI: drive a[63:32] and op 10, cin = captured low carry, binvert 0; ADD64 drives b[63:32]; SUB64 drives ~b[63:32] (ALU forces cin=1 when binvert=1, so borrow propagation SHALL use pre-inverted operand).
REQ-021 32-bit commands: resp_data = {32'h0, low result}, resp_cout = ALU carry (0 for AND/OR), resp_zero = low zero; operand bits [63:32] ignored.
REQ-022 64-bit commands: resp_data = {hi, lo}, resp_cout = high carry, resp_zero = lo_zero & hi_zero.
REQ-023 Illegal cmd: resp_err = 1, resp_data = 0, resp_cout = 0, resp_zero = 0; else resp_err = 0.
REQ-024 RESP: resp_valid[granted] = 1, other bit 0, data stable until resp_ready[granted]; then update last_grant, return IDLE; no new grant in that cycle.
REQ-025 Latency from transfer edge: resp_valid at +2 cycles (32-bit), +3 (64-bit), +1 (illegal).
REQ-026 In IDLE and RESP, ALU outputs SHALL be 0 (op 00, binvert 0, cin 0).
REQ-027 Changes on req_* of a non-granted or already-transferred port SHALL not affect the operation in flight.

Reset
REQ-028 While rst sampled high: state IDLE, req_ready 0, resp_valid 0, resp_data 0, resp_cout/zero/err 0, busy 0, last_grant 1, ALU outputs 0.
REQ-029 rst mid-operation SHALL abort it; no response ever issued for the aborted request.

Verification
REQ-030 Port 0 ADD a=0x7FFFFFFF, b=1 -> resp_data 0x0000000080000000, cout 0, zero 0, resp_valid 2 cycles after transfer.
REQ-031 Port 1 ADD64 a=0x00000000FFFFFFFF, b=1 -> resp_data 0x0000000100000000, cout 0, zero 0, at +3 cycles.
REQ-032 Port 0 SUB64 a=0x0000000100000000, b=1 -> resp_data 0x00000000FFFFFFFF; SUB a=5, b=5 -> data 0, zero 1, cout 1.
REQ-033 Both ports valid continuously, resp_ready=1, RR_ENABLE=1 -> grants 0,1,0,1; RR_ENABLE=0 -> 0,0,0.
REQ-034 cmd 111 -> resp_err 1, data 0 at +1 cycle; resp_ready held 0 for 5 cycles -> resp_valid and data held stable.
REQ-035 rst asserted during EXEC_HI -> next cycle IDLE, resp_valid 0, busy 0, no response for that request.
